run_sequencer: RTL and testbench

Job sequencer that sits directly upstream of the single-cycle core's top level. It accepts a byte stream over a valid/ready handshake and writes it into the core's 256×8 data memory through a borrowed write port. It then holds the core's `start` (active-high core reset) and waits for `done` or a timeout. Finally it streams a fixed result window from data memory back out over a second valid/ready port.

---
 rtl/seq_pkg.sv | 23 ++
 rtl/run_sequencer.sv | 174 +++++++++++++++++
 tb/tb_run_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
//
// seq_pkg
// Shared types and widths for the run_sequencer job controller.
//   seq_state_t : job phases IDLE -> LOAD -> START -> RUN -> READ -> IDLE
//   ADDR_W      : data-memory address width
//   DATA_W      : data-memory byte width
//
`timescale 1ns/1ps

package seq_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        READ
    } seq_state_t;

endpackage : seq_pkg

// File: rtl/run_sequencer.sv
//
// run_sequencer
// Job sequencer in front of the single-cycle core. It streams a program/data
// image into the core's data memory, pulses the core's start (reset), waits
// for done or a timeout, then streams a fixed result window back out.
//
// Ports:
//   clk, reset (async, active-low)
//   s_valid/s_ready/s_data/s_last     : load byte stream in
//   mem_sel/mem_wr_en/mem_addr/
//   mem_wr_data/mem_rd_data           : borrowed data-memory port
//   core_start/core_done              : core control
//   m_valid/m_ready/m_data/m_last     : readback byte stream out
//   busy, err_ovf, err_timeout        : status
//
`timescale 1ns/1ps

module run_sequencer
    import seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LOAD_BASE = 8'd0,
    parameter logic [ADDR_W-1:0] RB_BASE   = 8'd64,
    parameter int                RB_LEN    = 8,
    parameter int                START_CYC = 2,
    parameter int                TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_sel,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              core_start,
    input  logic              core_done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              err_ovf,
    output logic              err_timeout
);

    seq_state_t        r_state;
    logic [ADDR_W:0]   r_loadCnt;
    logic [31:0]       r_cycCnt;
    logic [ADDR_W:0]   r_rbIdx;
    logic              r_busy;
    logic              r_errOvf;
    logic              r_errTimeout;

    logic              w_sHs;
    logic              w_mHs;
    logic [ADDR_W:0]   w_loadIdx;
    logic              w_wrBeat;
    logic              w_rbLast;

    // Handshakes and the load index. The beat accepted in IDLE is beat 0,
    // so the index is forced to zero there instead of relying on the counter.
    // The MSB of the index marks a saturated counter (256 beats written).
    assign w_sHs     = s_valid & s_ready;
    assign w_mHs     = m_valid & m_ready;
    assign w_loadIdx = (r_state == IDLE) ? '0 : r_loadCnt;
    assign w_wrBeat  = w_sHs & ~w_loadIdx[ADDR_W];
    assign w_rbLast  = (r_rbIdx == (ADDR_W+1)'(RB_LEN - 1));

    // Port decode from state. The sequencer also claims the memory port for
    // the write of the very first beat, which is taken while still in IDLE.
    assign s_ready     = (r_state == IDLE) || (r_state == LOAD);
    assign m_valid     = (r_state == READ);
    assign core_start  = (r_state == START);
    assign mem_sel     = (r_state == LOAD) || (r_state == READ) || w_wrBeat;
    assign mem_wr_en   = w_wrBeat;
    assign mem_wr_data = s_data;
    assign m_data      = mem_rd_data;
    assign m_last      = m_valid & w_rbLast;
    assign busy        = r_busy;
    assign err_ovf     = r_errOvf;
    assign err_timeout = r_errTimeout;

    // Address mux: readback window in READ, load window while loading,
    // zero otherwise so the idle bus is quiet.
    always_comb begin
        mem_addr = '0;
        if (r_state == READ) begin
            mem_addr = RB_BASE + r_rbIdx[ADDR_W-1:0];
        end else if ((r_state == LOAD) || w_wrBeat) begin
            mem_addr = LOAD_BASE + w_loadIdx[ADDR_W-1:0];
        end
    end

    // Job FSM with its three counters and the registered busy/error flags.
    // r_cycCnt is shared: it times the start pulse, then restarts at zero
    // to time the RUN phase. In RUN, done is checked before the timeout so
    // a done on the final RUN cycle is not reported as a timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_loadCnt    <= '0;
            r_cycCnt     <= '0;
            r_rbIdx      <= '0;
            r_busy       <= 1'b0;
            r_errOvf     <= 1'b0;
            r_errTimeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sHs) begin
                        r_errOvf     <= 1'b0;
                        r_errTimeout <= 1'b0;
                        r_loadCnt    <= (ADDR_W+1)'(1);
                        r_cycCnt     <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= s_last ? START : LOAD;
                    end
                end
                LOAD: begin
                    if (w_sHs) begin
                        if (!r_loadCnt[ADDR_W]) begin
                            r_loadCnt <= r_loadCnt + 1'b1;
                        end else begin
                            r_errOvf <= 1'b1;
                        end
                        if (s_last) begin
                            r_cycCnt <= '0;
                            r_state  <= START;
                        end
                    end
                end
                START: begin
                    if (r_cycCnt == 32'(START_CYC - 1)) begin
                        r_cycCnt <= '0;
                        r_state  <= RUN;
                    end else begin
                        r_cycCnt <= r_cycCnt + 32'd1;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        r_rbIdx <= '0;
                        r_state <= READ;
                    end else if (r_cycCnt == 32'(TIMEOUT - 1)) begin
                        r_errTimeout <= 1'b1;
                        r_rbIdx      <= '0;
                        r_state      <= READ;
                    end else begin
                        r_cycCnt <= r_cycCnt + 32'd1;
                    end
                end
                READ: begin
                    if (w_mHs) begin
                        if (w_rbLast) begin
                            r_loadCnt <= '0;
                            r_busy    <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_rbIdx <= r_rbIdx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : run_sequencer

// File: tb/tb_run_sequencer.sv
//
// tb_run_sequencer
// Self-checking bench for run_sequencer. The bench owns the 256x8 data
// memory and keeps a separate expected image of it, built from the load
// rules (beat n lands at LOAD_BASE+n, only the first 256 beats land).
// Job timing and flags are predicted from the phase lengths directly.
//
`timescale 1ns/1ps

module tb_run_sequencer;

   localparam int         TIMEOUT_T   = 16;
   localparam int         RB_LEN_T    = 8;
   localparam int         START_CYC_T = 2;
   localparam logic [7:0] LOAD_BASE_T = 8'd0;
   localparam logic [7:0] RB_BASE_T   = 8'd64;

   logic       clk = 1'b0;
   logic       reset;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       s_last;
   logic       mem_sel;
   logic       mem_wr_en;
   logic [7:0] mem_addr;
   logic [7:0] mem_wr_data;
   logic [7:0] mem_rd_data;
   logic       core_start;
   logic       core_done;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       m_last;
   logic       busy;
   logic       err_ovf;
   logic       err_timeout;

   logic [7:0] seedMem [256];
   logic [7:0] physMem [256];
   logic [7:0] refMem  [256];
   logic       memLoaded  = 1'b0;
   int         writeCount = 0;
   int         checks     = 0;
   int         errors     = 0;

   run_sequencer #(
      .LOAD_BASE (LOAD_BASE_T),
      .RB_BASE   (RB_BASE_T),
      .RB_LEN    (RB_LEN_T),
      .START_CYC (START_CYC_T),
      .TIMEOUT   (TIMEOUT_T)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .mem_sel     (mem_sel),
      .mem_wr_en   (mem_wr_en),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data),
      .core_start  (core_start),
      .core_done   (core_done),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last),
      .busy        (busy),
      .err_ovf     (err_ovf),
      .err_timeout (err_timeout)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   // Data memory: combinational read, write on the clock edge only when the
   // sequencer owns the port. The first edge copies in the random seed image.
   assign mem_rd_data = physMem[mem_addr];

   always @(posedge clk) begin
      if (!memLoaded) begin
         for (int k = 0; k < 256; k++) physMem[k] <= seedMem[k];
         memLoaded <= 1'b1;
      end else if (mem_sel && mem_wr_en) begin
         physMem[mem_addr] <= mem_wr_data;
         writeCount        <= writeCount + 1;
      end
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic last,
                                input logic done, input logic ready);
      s_valid   = valid;
      s_data    = data;
      s_last    = last;
      core_done = done;
      m_ready   = ready;
   endtask

   // One full job. dataMode 1 loads 11,22,33,... ; doneDelay <0 never signals
   // done; readyMode 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random;
   // abortAt >= 0 pulls reset during that readback beat.
   task automatic runJob(input int len, input int dataMode, input int doneDelay,
                         input int readyMode, input int abortAt);
      int         wc0;
      int         runCycles;
      int         expRun;
      int         rbIdx;
      int         cyc;
      int         diffs;
      logic       rdy;
      logic       expTimeout;
      logic [7:0] b;
      logic [3:0] pattern;
      pattern = 4'b1001;
      wc0     = writeCount;

      for (int n = 0; n < len; n++) begin
         b = (dataMode == 1) ? 8'(8'h11 * (n + 1)) : 8'($urandom);
         applyStimulus(1'b1, b, (n == len - 1), 1'b0, 1'b0);
         #1;
         checkOutput("load_s_ready", s_ready, 1);
         checkOutput("load_mem_sel", mem_sel, 1);
         checkOutput("load_wr_en", mem_wr_en, (n < 256));
         if (n < 256) begin
            checkOutput("load_addr", mem_addr, 8'(LOAD_BASE_T + n));
            checkOutput("load_wr_data", mem_wr_data, b);
            refMem[8'(LOAD_BASE_T + n)] = b;
         end
         tick();
         if (n == 0) begin
            checkOutput("first_beat_err_ovf", err_ovf, 0);
            checkOutput("first_beat_err_timeout", err_timeout, 0);
            checkOutput("first_beat_busy", busy, 1);
         end
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("write_count", writeCount - wc0, (len > 256) ? 256 : len);
      checkOutput("err_ovf", err_ovf, (len > 256));

      for (int c = 0; c < START_CYC_T; c++) begin
         checkOutput("start_core_start", core_start, 1);
         checkOutput("start_s_ready", s_ready, 0);
         checkOutput("start_mem_sel", mem_sel, 0);
         tick();
      end

      expTimeout = !(doneDelay >= 0 && doneDelay < TIMEOUT_T);
      expRun     = expTimeout ? TIMEOUT_T : doneDelay + 1;
      runCycles  = 0;
      while (runCycles < 200) begin
         core_done = (runCycles == doneDelay);
         #1;
         if (m_valid) break;
         checkOutput("run_core_start", core_start, 0);
         checkOutput("run_mem_sel", mem_sel, 0);
         tick();
         runCycles++;
      end
      core_done = 1'b0;
      checkOutput("run_length", runCycles, expRun);
      checkOutput("err_timeout", err_timeout, expTimeout);

      rbIdx = 0;
      cyc   = 0;
      while (rbIdx < RB_LEN_T && cyc < 200) begin
         case (readyMode)
            0:       rdy = 1'b1;
            1:       rdy = pattern[3 - (cyc % 4)];
            default: rdy = 1'($urandom);
         endcase
         m_ready = rdy;
         #1;
         checkOutput("rb_m_valid", m_valid, 1);
         checkOutput("rb_addr", mem_addr, 8'(RB_BASE_T + rbIdx));
         checkOutput("rb_data", m_data, refMem[8'(RB_BASE_T + rbIdx)]);
         checkOutput("rb_last", m_last, (rbIdx == RB_LEN_T - 1));
         if (rbIdx == abortAt) begin
            reset = 1'b0;
            tick();
            checkOutput("abort_m_valid", m_valid, 0);
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_s_ready", s_ready, 1);
            m_ready = 1'b0;
            reset   = 1'b1;
            tick();
            return;
         end
         tick();
         cyc++;
         if (rdy) rbIdx++;
      end
      m_ready = 1'b0;
      #1;
      checkOutput("rb_beats", rbIdx, RB_LEN_T);
      checkOutput("end_busy", busy, 0);
      checkOutput("end_m_valid", m_valid, 0);
      checkOutput("end_s_ready", s_ready, 1);

      diffs = 0;
      for (int k = 0; k < 256; k++) if (physMem[k] !== refMem[k]) diffs++;
      checkOutput("mem_image", diffs, 0);
   endtask

   // Directed job sequence followed by a few fully random jobs.
   initial begin
      for (int k = 0; k < 256; k++) begin
         seedMem[k] = 8'($urandom);
         refMem[k]  = seedMem[k];
      end
      reset = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();

      checkOutput("rst_s_ready", s_ready, 1);
      checkOutput("rst_core_start", core_start, 0);
      checkOutput("rst_m_valid", m_valid, 0);
      checkOutput("rst_m_last", m_last, 0);
      checkOutput("rst_mem_sel", mem_sel, 0);
      checkOutput("rst_mem_wr_en", mem_wr_en, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_m_data", m_data, refMem[0]);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_err_ovf", err_ovf, 0);
      checkOutput("rst_err_timeout", err_timeout, 0);

      reset = 1'b1;
      tick();

      $display("[TB] basic job");
      runJob(4, 1, 5, 0, -1);
      checkOutput("basic_mem0", physMem[0], 8'h11);
      checkOutput("basic_mem1", physMem[1], 8'h22);
      checkOutput("basic_mem2", physMem[2], 8'h33);
      checkOutput("basic_mem3", physMem[3], 8'h44);

      $display("[TB] readback backpressure");
      runJob($urandom_range(70, 120), 0, 3, 1, -1);

      $display("[TB] load overflow");
      runJob(260, 0, 2, 2, -1);

      $display("[TB] run timeout");
      runJob(5, 0, -1, 0, -1);

      $display("[TB] flags clear on next job");
      runJob(3, 0, 1, 2, -1);

      $display("[TB] done on final run cycle");
      runJob(10, 0, TIMEOUT_T - 1, 0, -1);

      $display("[TB] reset during readback");
      runJob(80, 0, 4, 0, 3);
      runJob(90, 0, $urandom_range(0, 10), 2, -1);

      $display("[TB] random jobs");
      for (int j = 0; j < 4; j++) begin
         runJob($urandom_range(1, 300), 0, $urandom_range(0, 20), 2, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_run_sequencer
